seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 80 ++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment multiplexed scan with PWM dimming and double-buffered digit patterns
module seg_scan_ctrl #(
    parameter int SLOT_CYCLES = 40000,
    parameter int CBITS       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] brightness,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_addr,
    input  logic [6:0] wr_data,
    input  logic       commit,
    output logic       commit_ack,
    output logic [6:0] segment,
    output logic [3:0] digit_en,
    output logic       frame_done
);
    logic [CBITS-1:0] cnt;
    logic [1:0]       idx;
    logic [2:0]       pwm;
    logic             pending;
    logic [6:0]       shadow [4];
    logic [6:0]       active [4];
    logic             slot_end;
    logic             boundary;
    logic             lit;
    logic             publish;
    assign slot_end = cnt == CBITS'(SLOT_CYCLES - 1);
    assign boundary = enable & slot_end & (idx == 2'd3);
    assign lit      = enable & (pwm <= brightness);
    assign publish  = boundary & pending;
    // Writes are refused only while the shadow is being copied, so the copy is never torn.
    assign wr_ready = ~publish;
    // Slot counter, digit index and PWM phase advance only while scanning is enabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
            idx <= 2'd0;
            pwm <= 3'd0;
        end else if (enable) begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            idx <= slot_end ? idx + 2'd1 : idx;
            pwm <= slot_end ? 3'd0 : pwm + 3'd1;
        end
    end
    // Registered display drive and frame/commit status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            segment    <= 7'd0;
            digit_en   <= 4'd0;
            frame_done <= 1'b0;
            commit_ack <= 1'b0;
        end else begin
            segment    <= lit ? active[idx] : 7'd0;
            digit_en   <= lit ? 4'b0001 << idx : 4'd0;
            frame_done <= boundary;
            commit_ack <= publish;
        end
    end
    // Shadow writes, commit request tracking and frame-aligned publish to the active buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 7'd0;
                active[i] <= 7'd0;
            end
        end else begin
            if (wr_valid && wr_ready)
                shadow[wr_addr] <= wr_data;
            if (publish)
                for (int i = 0; i < 4; i++)
                    active[i] <= shadow[i];
            // A commit arriving while a publish is underway is absorbed by that publish.
            pending <= publish ? 1'b0 : pending | commit;
        end
    end
endmodule
